shift_lpf_cfg_sequencer: RTL and testbench
==========================================

Name: shift_lpf_cfg_sequencer

Overview:
- Reconfigures the frequency-shift + CIC + FIR low-pass chain at runtime.
- Host software writes FIR coefficients into a local register bank, then issues a start command.
- The sequencer then:
  - holds the upstream sample stream;
  - waits for the pipeline to drain;
  - streams the coefficients into the FIR reload port;
  - delivers the new phase increment to the mixer;
  - releases the stream.
- It sits between the host register interface and the reload/phase ports of the shift-and-LPF datapath.

Parameters:
COEFF_WIDTH, 16, FIR coefficient width.
NUM_COEFFS, 128, coefficients streamed per reload. Must be ≥2.
PHASE_WIDTH, 24, mixer phase-increment width.
FLUSH_CYCLES, 64, drain cycles with the stream held before the reload starts. Must be ≥1.
PHASE_TIMEOUT, 1024, max cycles to wait for phase_tready before aborting. Must be ≥1.
ADDR_WIDTH, $clog2(NUM_COEFFS), coefficient address width (derived).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
cfg_coeff_wr  in  1  coefficient write strobe
cfg_coeff_addr  in  ADDR_WIDTH  coefficient index
cfg_coeff_data  in  COEFF_WIDTH  coefficient value
cfg_phase  in  PHASE_WIDTH  new phase increment, sampled at start
cfg_start  in  1  start reconfiguration (single-cycle pulse)
cfg_busy  out  1  sequence in progress
cfg_done  out  1  one-cycle completion pulse
cfg_err  out  1  sticky error flag
dp_hold  out  1  1 = upstream must stop presenting in_tvalid
coeff_in  out  COEFF_WIDTH  FIR reload data
reload_tvalid  out  1  FIR reload valid
reload_tlast  out  1  last coefficient
phase_tdata  out  PHASE_WIDTH  phase increment to mixer
phase_tvalid  out  1  phase valid
phase_tlast  out  1  always equal to phase_tvalid
phase_tready  in  1  mixer accepts phase

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; cfg_err 0. Coefficient bank is not reset (contents undefined until written).
- Reset mid-sequence: dp_hold and all valids drop at once. A partially streamed coefficient set is abandoned; the FIR retains what it latched.
- States: IDLE → DRAIN → LOAD → PHASE → DONE → IDLE.
- IDLE:
  - cfg_coeff_wr with addr < NUM_COEFFS writes the bank; addr ≥ NUM_COEFFS is ignored.
  - cfg_start latches cfg_phase, clears cfg_err, and moves to DRAIN next cycle.
  - If a write and start occur in the same cycle, the write is committed and used in this sequence.
- Writes or start outside IDLE are ignored and set cfg_err=1.
- DRAIN:
  - dp_hold=1 and cfg_busy=1 from the first DRAIN cycle.
  - Lasts exactly FLUSH_CYCLES cycles, counted by a down-counter, then LOAD.
- LOAD:
  - reload_tvalid=1 for exactly NUM_COEFFS consecutive cycles. The reload port has no backpressure.
  - Beat k carries bank[k], k=0..NUM_COEFFS-1, in ascending order.
  - reload_tlast=1 only on beat NUM_COEFFS-1. Registered output, no bubbles.
  - Next cycle: PHASE.
- PHASE:
  - phase_tvalid=phase_tlast=1 and phase_tdata=latched phase, held stable until phase_tready.
  - The handshake completes in a cycle with tvalid&tready; then go to DONE.
  - If PHASE_TIMEOUT cycles elapse without tready: drop valid, set cfg_err=1, go to DONE.
- DONE (1 cycle): cfg_done=1, dp_hold=0, cfg_busy=0. Then IDLE.
- cfg_busy=1 exactly in DRAIN, LOAD and PHASE.
- Total latency from start to done (tready already high): 1 + FLUSH_CYCLES + NUM_COEFFS + 1 cycles, with done in the following cycle.
- cfg_err is cleared only by reset or by an accepted cfg_start.

Test Plan:
- NUM_COEFFS=8, FLUSH_CYCLES=4. Write bank[k]=0x100+k, start with cfg_phase=0x123456, phase_tready=1 → dp_hold high 14 cycles; reload beats 0x100..0x107 with tlast on 0x107; a single phase beat 0x123456; cfg_done at cycle 15 after start; cfg_err=0.
- phase_tready low for 10 cycles during PHASE (PHASE_TIMEOUT=1024) → phase_tdata/tvalid stable for 10 cycles, accepted on cycle 11, then cfg_done; cfg_err=0.
- phase_tready held low, PHASE_TIMEOUT=16 → phase_tvalid drops after 16 cycles; cfg_err=1; cfg_done pulses; dp_hold released. Next start clears cfg_err.
- cfg_start and cfg_coeff_wr in DRAIN/LOAD → ignored (bank and stream unchanged, sequence not restarted); cfg_err=1. Write with addr=8 when NUM_COEFFS=8 (ADDR_WIDTH=3 cannot encode 8; use NUM_COEFFS=6, addr=6) → no bank change.
- Same-cycle write bank[0]=0xBEEF and start → first reload beat is 0xBEEF.
- reset_n asserted at beat 3 of LOAD → all outputs 0 asynchronously. After release, state is IDLE and a new start runs a full sequence from beat 0.

Source files
------------

// File: rtl/shift_lpf_cfg_sequencer_if.sv
// Bundle of the host configuration bus, the FIR coefficient reload stream and
// the mixer phase-increment stream handled by shift_lpf_cfg_sequencer.
interface shift_lpf_cfg_sequencer_if #(
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_COEFFS  = 128,
  parameter int PHASE_WIDTH = 24,
  parameter int ADDR_WIDTH  = $clog2(NUM_COEFFS)
);
  // Host register side
  logic                   cfg_coeff_wr;
  logic [ADDR_WIDTH-1:0]  cfg_coeff_addr;
  logic [COEFF_WIDTH-1:0] cfg_coeff_data;
  logic [PHASE_WIDTH-1:0] cfg_phase;
  logic                   cfg_start;
  logic                   cfg_busy;
  logic                   cfg_done;
  logic                   cfg_err;
  // Datapath side
  logic                   dp_hold;
  logic [COEFF_WIDTH-1:0] coeff_in;
  logic                   reload_tvalid;
  logic                   reload_tlast;
  logic [PHASE_WIDTH-1:0] phase_tdata;
  logic                   phase_tvalid;
  logic                   phase_tlast;
  logic                   phase_tready;

  // Environment view: host writes and the mixer's ready.
  modport master (
    output cfg_coeff_wr, cfg_coeff_addr, cfg_coeff_data, cfg_phase, cfg_start,
    output phase_tready,
    input  cfg_busy, cfg_done, cfg_err, dp_hold, coeff_in, reload_tvalid,
    input  reload_tlast, phase_tdata, phase_tvalid, phase_tlast
  );

  // Sequencer view.
  modport slave (
    input  cfg_coeff_wr, cfg_coeff_addr, cfg_coeff_data, cfg_phase, cfg_start,
    input  phase_tready,
    output cfg_busy, cfg_done, cfg_err, dp_hold, coeff_in, reload_tvalid,
    output reload_tlast, phase_tdata, phase_tvalid, phase_tlast
  );
endinterface

// File: rtl/shift_lpf_cfg_sequencer.sv
// Runtime reconfiguration sequencer for the frequency-shift + CIC + FIR chain.
// Holds the upstream stream, drains the pipeline, streams the coefficient bank
// into the FIR reload port, hands the new phase increment to the mixer and
// releases the stream again.
module shift_lpf_cfg_sequencer #(
  parameter int COEFF_WIDTH   = 16,
  parameter int NUM_COEFFS    = 128,
  parameter int PHASE_WIDTH   = 24,
  parameter int FLUSH_CYCLES  = 64,
  parameter int PHASE_TIMEOUT = 1024,
  parameter int ADDR_WIDTH    = $clog2(NUM_COEFFS)
) (
  input  logic clk,
  input  logic reset_n,
  shift_lpf_cfg_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DRAIN = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] PHASE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam int TOUT_W  = $clog2(PHASE_TIMEOUT + 1);

  // One extra bit so the bound is representable when NUM_COEFFS is a power of two.
  localparam logic [ADDR_WIDTH:0]   NUM_COEFFS_W = (ADDR_WIDTH + 1)'(NUM_COEFFS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX     = ADDR_WIDTH'(NUM_COEFFS - 1);
  localparam logic [FLUSH_W-1:0]    FLUSH_LOAD   = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [TOUT_W-1:0]     TOUT_LAST    = TOUT_W'(PHASE_TIMEOUT - 1);

  logic                   rst_meta_r;
  logic                   rst_sync_r;

  logic [COEFF_WIDTH-1:0] bank_r [NUM_COEFFS];

  logic [2:0]             state_r;
  logic [FLUSH_W-1:0]     flush_cnt_r;
  logic [ADDR_WIDTH-1:0]  beat_idx_r;
  logic [TOUT_W-1:0]      tout_cnt_r;
  logic [PHASE_WIDTH-1:0] phase_r;

  logic                   busy_r;
  logic                   done_r;
  logic                   err_r;
  logic                   hold_r;
  logic [COEFF_WIDTH-1:0] coeff_r;
  logic                   reload_tvalid_r;
  logic                   reload_tlast_r;
  logic [PHASE_WIDTH-1:0] phase_tdata_r;
  logic                   phase_tvalid_r;

  logic                   wr_ok_s;
  logic                   start_ok_s;
  logic                   bad_access_s;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  // Host accesses are legal only while idle; anything else is flagged.
  always_comb begin
    wr_ok_s      = 1'b0;
    start_ok_s   = 1'b0;
    bad_access_s = 1'b0;
    if (state_r == IDLE) begin
      wr_ok_s    = bus.cfg_coeff_wr && ({1'b0, bus.cfg_coeff_addr} < NUM_COEFFS_W);
      start_ok_s = bus.cfg_start;
    end else begin
      bad_access_s = bus.cfg_coeff_wr || bus.cfg_start;
    end
  end

  // Coefficient bank: no reset, a write coinciding with start is still taken.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      bank_r[bus.cfg_coeff_addr] <= bus.cfg_coeff_data;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      state_r         <= IDLE;
      flush_cnt_r     <= '0;
      beat_idx_r      <= '0;
      tout_cnt_r      <= '0;
      phase_r         <= '0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      err_r           <= 1'b0;
      hold_r          <= 1'b0;
      coeff_r         <= '0;
      reload_tvalid_r <= 1'b0;
      reload_tlast_r  <= 1'b0;
      phase_tdata_r   <= '0;
      phase_tvalid_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bad_access_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            phase_r     <= bus.cfg_phase;
            err_r       <= 1'b0;
            hold_r      <= 1'b1;
            busy_r      <= 1'b1;
            flush_cnt_r <= FLUSH_LOAD;
            state_r     <= DRAIN;
          end
        end
        DRAIN: begin
          if (flush_cnt_r == '0) begin
            beat_idx_r <= '0;
            state_r    <= LOAD;
          end else begin
            flush_cnt_r <= flush_cnt_r - FLUSH_W'(1);
          end
        end
        LOAD: begin
          // One beat per cycle; the reload port never back-pressures.
          reload_tvalid_r <= 1'b1;
          coeff_r         <= bank_r[beat_idx_r];
          reload_tlast_r  <= (beat_idx_r == LAST_IDX);
          if (beat_idx_r == LAST_IDX) begin
            state_r <= PHASE;
          end else begin
            beat_idx_r <= beat_idx_r + ADDR_WIDTH'(1);
          end
        end
        PHASE: begin
          reload_tvalid_r <= 1'b0;
          reload_tlast_r  <= 1'b0;
          coeff_r         <= '0;
          if (!phase_tvalid_r) begin
            phase_tvalid_r <= 1'b1;
            phase_tdata_r  <= phase_r;
            tout_cnt_r     <= '0;
          end else if (bus.phase_tready || (tout_cnt_r == TOUT_LAST)) begin
            // Accepted, or the mixer never answered: either way finish up.
            phase_tvalid_r <= 1'b0;
            phase_tdata_r  <= '0;
            hold_r         <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b1;
            state_r        <= DONE;
            if (!bus.phase_tready) begin
              err_r <= 1'b1;
            end
          end else begin
            tout_cnt_r <= tout_cnt_r + TOUT_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r         <= IDLE;
          busy_r          <= 1'b0;
          hold_r          <= 1'b0;
          reload_tvalid_r <= 1'b0;
          reload_tlast_r  <= 1'b0;
          phase_tvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_busy      = busy_r;
  assign bus.cfg_done      = done_r;
  assign bus.cfg_err       = err_r;
  assign bus.dp_hold       = hold_r;
  assign bus.coeff_in      = coeff_r;
  assign bus.reload_tvalid = reload_tvalid_r;
  assign bus.reload_tlast  = reload_tlast_r;
  assign bus.phase_tdata   = phase_tdata_r;
  assign bus.phase_tvalid  = phase_tvalid_r;
  assign bus.phase_tlast   = phase_tvalid_r;

endmodule

// File: tb/tb_shift_lpf_cfg_sequencer.sv
// Randomised self-checking bench for shift_lpf_cfg_sequencer. Expected timing
// is derived from the sequence rules (start, FLUSH drain cycles, one reload
// beat per coefficient, phase handshake, one done cycle); the bank contents
// are tracked in a plain array.
module tb_shift_lpf_cfg_sequencer;

  localparam int CW     = 16;
  localparam int NC     = 6;
  localparam int PW     = 24;
  localparam int FL     = 4;
  localparam int TO     = 16;
  localparam int AW     = $clog2(NC);
  localparam int BUDGET = FL + NC + TO + 12;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  shift_lpf_cfg_sequencer_if #(
    .COEFF_WIDTH(CW), .NUM_COEFFS(NC), .PHASE_WIDTH(PW), .ADDR_WIDTH(AW)
  ) bus ();

  shift_lpf_cfg_sequencer #(
    .COEFF_WIDTH(CW), .NUM_COEFFS(NC), .PHASE_WIDTH(PW),
    .FLUSH_CYCLES(FL), .PHASE_TIMEOUT(TO), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [CW-1:0] ref_bank [NC];
  logic          exp_err  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_busy"},   32'(bus.cfg_busy),      32'(0));
    check_val({pfx, "_done"},   32'(bus.cfg_done),      32'(0));
    check_val({pfx, "_err"},    32'(bus.cfg_err),       32'(0));
    check_val({pfx, "_hold"},   32'(bus.dp_hold),       32'(0));
    check_val({pfx, "_coeff"},  32'(bus.coeff_in),      32'(0));
    check_val({pfx, "_rvalid"}, 32'(bus.reload_tvalid), 32'(0));
    check_val({pfx, "_rlast"},  32'(bus.reload_tlast),  32'(0));
    check_val({pfx, "_pdata"},  32'(bus.phase_tdata),   32'(0));
    check_val({pfx, "_pvalid"}, 32'(bus.phase_tvalid),  32'(0));
    check_val({pfx, "_plast"},  32'(bus.phase_tlast),   32'(0));
  endtask

  task automatic write_coeff(input int addr, input logic [CW-1:0] data);
    bus.cfg_coeff_wr   = 1'b1;
    bus.cfg_coeff_addr = AW'(addr);
    bus.cfg_coeff_data = data;
    @(negedge clk);
    bus.cfg_coeff_wr = 1'b0;
    if (addr < NC) begin
      ref_bank[addr] = data;
    end
  endtask

  // rdy: number of valid cycles with tready low before acceptance; -1 = never.
  task automatic run_seq(input string name, input logic [PW-1:0] ph, input int rdy,
                         input bit poke, input bit same_wr, input int same_addr,
                         input logic [CW-1:0] same_data);
    int            hold_n = 0;
    int            hold_first = -1;
    int            busy_bad = 0;
    int            beat_first = -1;
    int            beat_last = -1;
    int            tlast_n = 0;
    int            tlast_at = -1;
    int            pv_n = 0;
    int            pv_first = -1;
    int            pdata_bad = 0;
    int            ptl_bad = 0;
    int            done_n = 0;
    int            done_cyc = -1;
    int            v_exp;
    logic [CW-1:0] beats [$];

    v_exp = (rdy < 0) ? TO : rdy + 1;
    bus.cfg_start      = 1'b1;
    bus.cfg_phase      = ph;
    bus.phase_tready   = (rdy == 0);
    bus.cfg_coeff_wr   = same_wr;
    bus.cfg_coeff_addr = AW'(same_addr);
    bus.cfg_coeff_data = same_data;
    if (same_wr && same_addr < NC) begin
      ref_bank[same_addr] = same_data;
    end
    exp_err = 1'b0;

    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      bus.cfg_start    = 1'b0;
      bus.cfg_coeff_wr = 1'b0;
      if (cyc == 1) begin
        check_val({name, "_err_cleared"}, 32'(bus.cfg_err), 32'(0));
      end
      if (bus.dp_hold) begin
        hold_n++;
        if (hold_first < 0) hold_first = cyc;
      end
      if (bus.cfg_busy !== bus.dp_hold) busy_bad++;
      if (bus.reload_tvalid) begin
        beats.push_back(bus.coeff_in);
        if (beat_first < 0) beat_first = cyc;
        beat_last = cyc;
        if (bus.reload_tlast) begin
          tlast_n++;
          tlast_at = beats.size() - 1;
        end
      end
      if (bus.phase_tvalid) begin
        pv_n++;
        if (pv_first < 0) pv_first = cyc;
        if (bus.phase_tdata !== ph) pdata_bad++;
      end
      if (bus.phase_tlast !== bus.phase_tvalid) ptl_bad++;
      if (bus.cfg_done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      bus.phase_tready = (rdy == 0) || (rdy > 0 && bus.phase_tvalid && pv_n > rdy);
      if (poke && (cyc == 2 || cyc == FL + 4)) begin
        bus.cfg_start      = 1'b1;
        bus.cfg_coeff_wr   = 1'b1;
        bus.cfg_coeff_addr = AW'(cyc % NC);
        bus.cfg_coeff_data = ~ref_bank[cyc % NC];
        exp_err = 1'b1;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    bus.phase_tready = 1'b0;
    if (rdy < 0) exp_err = 1'b1;

    check_val({name, "_hold_first"},  32'(hold_first), 32'(1));
    check_val({name, "_hold_cycles"}, 32'(hold_n), 32'(FL + NC + 1 + v_exp));
    check_val({name, "_busy_eq_hold"}, 32'(busy_bad), 32'(0));
    check_val({name, "_beat_first"},  32'(beat_first), 32'(FL + 2));
    check_val({name, "_beat_span"},   32'(beat_last - beat_first + 1), 32'(NC));
    check_val({name, "_beat_count"},  32'(beats.size()), 32'(NC));
    for (int k = 0; k < NC && k < beats.size(); k++) begin
      check_val($sformatf("%s_beat%0d", name, k), 32'(beats[k]), 32'(ref_bank[k]));
    end
    check_val({name, "_tlast_count"}, 32'(tlast_n), 32'(1));
    check_val({name, "_tlast_pos"},   32'(tlast_at), 32'(NC - 1));
    check_val({name, "_pv_first"},    32'(pv_first), 32'(FL + NC + 2));
    check_val({name, "_pv_cycles"},   32'(pv_n), 32'(v_exp));
    check_val({name, "_pdata_stable"}, 32'(pdata_bad), 32'(0));
    check_val({name, "_plast_eq_pvalid"}, 32'(ptl_bad), 32'(0));
    check_val({name, "_done_cycle"},  32'(done_cyc), 32'(FL + NC + 2 + v_exp));
    check_val({name, "_done_pulses"}, 32'(done_n), 32'(1));
    check_val({name, "_err_end"},     32'(bus.cfg_err), 32'(exp_err));
    check_val({name, "_hold_released"}, 32'(bus.dp_hold), 32'(0));
  endtask

  task automatic reset_mid_load();
    bus.cfg_start    = 1'b1;
    bus.cfg_phase    = 24'h0ABCDE;
    bus.phase_tready = 1'b1;
    for (int cyc = 1; cyc <= FL + 5; cyc++) begin
      @(negedge clk);
      bus.cfg_start = 1'b0;
    end
    check_val("mid_beat3_valid", 32'(bus.reload_tvalid), 32'(1));
    check_val("mid_beat3_data",  32'(bus.coeff_in), 32'(ref_bank[3]));
    reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.phase_tready = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("post_rst");
    exp_err = 1'b0;
  endtask

  initial begin
    int      rdy;
    int      sel;
    int      nwr;
    bit      pk;
    bit      sw;

    reset_n            = 1'b0;
    bus.cfg_coeff_wr   = 1'b0;
    bus.cfg_coeff_addr = '0;
    bus.cfg_coeff_data = '0;
    bus.cfg_phase      = '0;
    bus.cfg_start      = 1'b0;
    bus.phase_tready   = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("idle");

    for (int k = 0; k < NC; k++) write_coeff(k, 16'h0100 + 16'(k));
    run_seq("basic", 24'h123456, 0, 1'b0, 1'b0, 0, 16'h0000);

    for (int k = 0; k < NC; k++) write_coeff(k, 16'($urandom));
    run_seq("rdy10",     24'($urandom), 10, 1'b0, 1'b0, 0, 16'h0000);
    run_seq("timeout",   24'($urandom), -1, 1'b0, 1'b0, 0, 16'h0000);
    run_seq("err_clear", 24'($urandom), 0,  1'b0, 1'b0, 0, 16'h0000);
    run_seq("poke",      24'($urandom), 3,  1'b1, 1'b0, 0, 16'h0000);

    write_coeff(6, 16'h5A5A);
    write_coeff(7, 16'hA5A5);
    check_val("oor_err_kept", 32'(bus.cfg_err), 32'(exp_err));
    run_seq("same_cycle", 24'($urandom), 0, 1'b0, 1'b1, 0, 16'hBEEF);

    reset_mid_load();
    run_seq("after_reset", 24'($urandom), 2, 1'b0, 1'b0, 0, 16'h0000);

    for (int i = 0; i < 5; i++) begin
      nwr = $urandom_range(1, 3);
      for (int w = 0; w < nwr; w++) write_coeff($urandom_range(0, 7), 16'($urandom));
      sel = $urandom_range(0, 3);
      rdy = (sel == 0) ? 0 : (sel == 1) ? -1 : $urandom_range(1, 14);
      pk  = 1'($urandom_range(0, 1));
      sw  = 1'($urandom_range(0, 1));
      run_seq($sformatf("rand%0d", i), 24'($urandom), rdy, pk, sw,
              $urandom_range(0, 7), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
